// File: rtl/mem_bus_sched_if.sv
// Requester-side bundle for the memory bus scheduler.
// Fetch line reads and LSB loads/stores share one interface.
interface mem_bus_sched_if #(
    parameter int LINE_BYTES = 64
);
    logic                    if_en;
    logic [31:0]             if_pc;
    logic                    if_done;
    logic [8*LINE_BYTES-1:0] if_data;

    logic                    lsb_en;
    logic                    lsb_wr;
    logic [31:0]             lsb_addr;
    logic [2:0]              lsb_len;
    logic [31:0]             lsb_w_data;
    logic                    lsb_done;
    logic [31:0]             lsb_r_data;

    modport master (
        output if_en, if_pc,
        output lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
        input  if_done, if_data,
        input  lsb_done, lsb_r_data
    );

    modport slave (
        input  if_en, if_pc,
        input  lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
        output if_done, if_data,
        output lsb_done, lsb_r_data
    );
endinterface

// File: rtl/mem_bus_sched.sv
// Byte-wide memory bus scheduler: arbitrates fetch line fills and
// LSB accesses, serialises bytes, handles I/O stalls and rollback.
module mem_bus_sched #(
    parameter int LINE_BYTES   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    input  logic           rollback,
    input  logic [7:0]     mem_din,
    output logic [7:0]     mem_dout,
    output logic [31:0]    mem_a,
    output logic           mem_wr,
    input  logic           io_buffer_full,
    mem_bus_sched_if.slave bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
    localparam logic [6:0] LINE_LEN = 7'(LINE_BYTES);
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        IF_RD,
        LSB_RD,
        LSB_WR
    } state_t;

    state_t state_q, state_d;

    logic [31:0]             base_q;
    logic [31:0]             wdata_q;
    logic [31:0]             a_last_q;
    logic [6:0]              len_q;
    logic [6:0]              idx_q;
    logic [6:0]              cap_idx_q;
    logic                    io_q;
    logic                    cap_vld_q;
    logic [CW-1:0]           starve_q;
    logic [8*LINE_BYTES-1:0] buf_q;
    logic [8*LINE_BYTES-1:0] buf_m;
    logic                    if_done_q;
    logic                    lsb_done_q;
    logic [8*LINE_BYTES-1:0] if_data_q;
    logic [31:0]             lsb_r_data_q;

    logic reading;
    logic driving;
    logic io_stall;
    logic issue;
    logic abort;
    logic last_cap;
    logic wr_last;
    logic can_grant;
    logic grant_if;
    logic grant_lsb;

    always_comb begin
        reading  = (state_q == IF_RD) || (state_q == LSB_RD);
        driving  = (state_q != IDLE) && (idx_q < len_q);
        io_stall = (state_q == LSB_WR) && io_q && io_buffer_full;
        issue    = driving && rdy && !io_stall;
        abort    = reading && rollback;
        last_cap = reading && cap_vld_q
                   && (cap_idx_q == len_q - 7'd1);
        mem_wr   = (state_q == LSB_WR) && issue;
        wr_last  = mem_wr && (idx_q == len_q - 7'd1);
        mem_a    = driving ? base_q + {25'd0, idx_q} : a_last_q;
        mem_dout = 8'h00;
        if (mem_wr) begin
            mem_dout = 8'(wdata_q >> {idx_q[1:0], 3'b000});
        end
    end

    // No grant in a done cycle: the requester still holds en then.
    always_comb begin
        can_grant = (state_q == IDLE) && rdy && !rollback
                    && !if_done_q && !lsb_done_q;
        grant_if  = can_grant && bus.if_en
                    && (!bus.lsb_en || starve_q == STARVE_MAX);
        grant_lsb = can_grant && bus.lsb_en && !grant_if;
    end

    // Incoming byte merged into the line buffer at its lane.
    always_comb begin
        buf_m = buf_q;
        for (int k = 0; k < LINE_BYTES; k++) begin
            if (cap_idx_q == k[6:0]) begin
                buf_m[8*k +: 8] = mem_din;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d = IF_RD;
                end else if (grant_lsb) begin
                    state_d = bus.lsb_wr ? LSB_WR : LSB_RD;
                end
            end
            IF_RD, LSB_RD: begin
                if (abort || last_cap) begin
                    state_d = IDLE;
                end
            end
            LSB_WR: begin
                if (wr_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q       <= '0;
            wdata_q      <= '0;
            a_last_q     <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            cap_idx_q    <= '0;
            io_q         <= 1'b0;
            cap_vld_q    <= 1'b0;
            starve_q     <= '0;
            buf_q        <= '0;
            if_done_q    <= 1'b0;
            lsb_done_q   <= 1'b0;
            if_data_q    <= '0;
            lsb_r_data_q <= '0;
        end else begin
            if_done_q  <= 1'b0;
            lsb_done_q <= 1'b0;
            a_last_q   <= mem_a;
            cap_vld_q  <= issue && reading && !abort;
            cap_idx_q  <= idx_q;
            if (issue) begin
                idx_q <= idx_q + 7'd1;
            end
            if (cap_vld_q) begin
                buf_q <= buf_m;
            end
            if (grant_if) begin
                base_q   <= bus.if_pc & LINE_MASK;
                len_q    <= LINE_LEN;
                idx_q    <= '0;
                buf_q    <= '0;
                io_q     <= 1'b0;
                starve_q <= '0;
            end
            if (grant_lsb) begin
                base_q  <= bus.lsb_addr;
                len_q   <= {4'd0, bus.lsb_len};
                wdata_q <= bus.lsb_w_data;
                io_q    <= (bus.lsb_addr[17:16] == 2'b11);
                idx_q   <= '0;
                buf_q   <= '0;
                if (bus.if_en && starve_q != STARVE_MAX) begin
                    starve_q <= starve_q + 1'b1;
                end
            end
            if (last_cap && !abort) begin
                if (state_q == IF_RD) begin
                    if_done_q <= 1'b1;
                    if_data_q <= buf_m;
                end else begin
                    lsb_done_q   <= 1'b1;
                    lsb_r_data_q <= buf_m[31:0];
                end
            end
            if (wr_last) begin
                lsb_done_q <= 1'b1;
            end
        end
    end

    assign bus.if_done    = if_done_q;
    assign bus.if_data    = if_data_q;
    assign bus.lsb_done   = lsb_done_q;
    assign bus.lsb_r_data = lsb_r_data_q;

endmodule

// File: tb/tb_mem_bus_sched.sv
// Directed bench for mem_bus_sched with a byte memory model and
// scoreboard queues for bus writes, LSB results and fetch lines.
module tb_mem_bus_sched;

    localparam int LB = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_bus_sched_if #(.LINE_BYTES(LB)) bus ();

    mem_bus_sched #(
        .LINE_BYTES(LB),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .rollback(rollback),
        .mem_din(mem_din),
        .mem_dout(mem_dout),
        .mem_a(mem_a),
        .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct packed {
        logic        on;
        logic [31:0] d;
    } rd_t;

    wr_t exp_wr[$];
    rd_t exp_lsb[$];
    logic [8*LB-1:0] exp_if[$];

    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        mem_din <= rd_byte(mem_a);
        if (mem_wr === 1'b1) mem[mem_a] = mem_dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkl(input string tag, input logic [8*LB-1:0] obs,
                        input logic [8*LB-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_rd(input logic [31:0] a, input int len);
        rd_t r;
        r.on = 1'b1;
        r.d = '0;
        for (int i = 0; i < len; i++) r.d[8*i +: 8] = rd_byte(a + 32'(i));
        exp_lsb.push_back(r);
    endfunction

    function automatic void push_wr(input logic [31:0] a, input int n,
                                    input logic [31:0] wd);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.a = a + 32'(i);
            w.d = wd[8*i +: 8];
            exp_wr.push_back(w);
        end
    endfunction

    function automatic void push_line(input logic [31:0] base);
        logic [8*LB-1:0] l;
        for (int k = 0; k < LB; k++) l[8*k +: 8] = rd_byte(base + 32'(k));
        exp_if.push_back(l);
    endfunction

    wr_t we;
    rd_t re;
    logic [8*LB-1:0] le;

    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", 32'(mem_wr), 32'd0);
            end else begin
                we = exp_wr.pop_front();
                chk("wr_addr", mem_a, we.a);
                chk("wr_data", 32'(mem_dout), 32'(we.d));
            end
        end
        if (bus.lsb_done === 1'b1) begin
            if (exp_lsb.size() == 0) begin
                chk("lsb_done_unexpected", 32'(bus.lsb_done), 32'd0);
            end else begin
                re = exp_lsb.pop_front();
                if (re.on) chk("lsb_r_data", bus.lsb_r_data, re.d);
            end
        end
        if (bus.if_done === 1'b1) begin
            if (exp_if.size() == 0) begin
                chk("if_done_unexpected", 32'(bus.if_done), 32'd0);
            end else begin
                le = exp_if.pop_front();
                chkl("if_data", bus.if_data, le);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_lsb(input logic wr, input logic [31:0] a,
                             input logic [2:0] len, input logic [31:0] wd,
                             output int t0);
        step();
        bus.lsb_en = 1'b1;
        bus.lsb_wr = wr;
        bus.lsb_addr = a;
        bus.lsb_len = len;
        bus.lsb_w_data = wd;
        t0 = cyc;
    endtask

    task automatic wait_lsb(input int t0, input int lat, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.lsb_done !== 1'b1 && n < 400);
        chk(tag, 32'(cyc - t0), 32'(lat));
        step();
        bus.lsb_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int t0;
    int got;
    int n;
    logic [5:0] seq;
    rd_t nochk;

    initial begin
        nochk = '0;
        bus.if_en = 1'b0;
        bus.if_pc = '0;
        bus.lsb_en = 1'b0;
        bus.lsb_wr = 1'b0;
        bus.lsb_addr = '0;
        bus.lsb_len = '0;
        bus.lsb_w_data = '0;
        mem[32'h1000] = 8'h11;
        mem[32'h1001] = 8'h22;
        mem[32'h1002] = 8'h33;
        mem[32'h1003] = 8'h44;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_if_done", 32'(bus.if_done), 32'd0);
        chk("rst_lsb_done", 32'(bus.lsb_done), 32'd0);
        chk("rst_lsb_r_data", bus.lsb_r_data, 32'd0);
        chkl("rst_if_data", bus.if_data, '0);
        step();
        rst = 1'b0;

        // 4-byte load: address sequence, no writes, done in cycle 6
        start_lsb(1'b0, 32'h1000, 3'd4, 32'd0, t0);
        push_rd(32'h1000, 4);
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("ld_addr", mem_a, 32'h1000 + 32'(i - 1));
            chk("ld_wr_low", 32'(mem_wr), 32'd0);
        end
        wait_lsb(t0, 6, "ld_latency");

        // 2-byte store
        start_lsb(1'b1, 32'h2002, 3'd2, 32'h0000BEEF, t0);
        push_wr(32'h2002, 2, 32'h0000BEEF);
        exp_lsb.push_back(nochk);
        @(negedge clk);
        @(negedge clk);
        chk("st_c1_addr", mem_a, 32'h2002);
        chk("st_c1_wr", 32'(mem_wr), 32'd1);
        wait_lsb(t0, 3, "st_latency");

        // anti-starvation: both requesters held high
        step();
        bus.if_en = 1'b1;
        bus.if_pc = 32'h4000;
        bus.lsb_en = 1'b1;
        bus.lsb_wr = 1'b0;
        bus.lsb_addr = 32'h0500;
        bus.lsb_len = 3'd1;
        for (int i = 0; i < 5; i++) push_rd(32'h0500, 1);
        push_line(32'h4000);
        seq = '0;
        got = 0;
        n = 0;
        while (got < 6 && n < 2000) begin
            @(negedge clk);
            n++;
            if (bus.if_done === 1'b1) begin
                seq = {seq[4:0], 1'b1};
                got++;
                step();
                bus.if_en = 1'b0;
            end else if (bus.lsb_done === 1'b1) begin
                seq = {seq[4:0], 1'b0};
                got++;
                if (got == 6) begin
                    step();
                    bus.lsb_en = 1'b0;
                end
            end
        end
        bus.if_en = 1'b0;
        bus.lsb_en = 1'b0;
        chk("starve_count", 32'(got), 32'd6);
        chk("starve_order", 32'(seq), 32'h02);

        // rollback in IDLE blocks the grant for one cycle
        start_lsb(1'b0, 32'h0520, 3'd1, 32'd0, t0);
        rollback = 1'b1;
        push_rd(32'h0520, 1);
        step();
        rollback = 1'b0;
        wait_lsb(t0, 4, "rb_idle_latency");

        // rollback in cycle 10 of a line fill, LSB pending
        step();
        bus.if_en = 1'b1;
        bus.if_pc = 32'h8123;
        t0 = cyc;
        repeat (5) step();
        bus.lsb_en = 1'b1;
        bus.lsb_wr = 1'b0;
        bus.lsb_addr = 32'h0600;
        bus.lsb_len = 3'd2;
        push_rd(32'h0600, 2);
        repeat (5) step();
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        bus.if_en = 1'b0;
        @(negedge clk);
        chk("rb_idle_hold_addr", mem_a, 32'h8109);
        @(negedge clk);
        chk("rb_lsb_first_addr", mem_a, 32'h0600);
        wait_lsb(t0 + 11, 4, "rb_lsb_latency");

        // rollback during a 4-byte store is ignored
        start_lsb(1'b1, 32'h0700, 3'd4, 32'hA1B2C3D4, t0);
        push_wr(32'h0700, 4, 32'hA1B2C3D4);
        exp_lsb.push_back(nochk);
        step();
        step();
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        wait_lsb(t0, 5, "rb_st_latency");

        // I/O store stalled 3 cycles by a full buffer
        start_lsb(1'b1, 32'h0003_0000, 3'd1, 32'h0000_0041, t0);
        io_buffer_full = 1'b1;
        push_wr(32'h0003_0000, 1, 32'h0000_0041);
        exp_lsb.push_back(nochk);
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("io_stall_wr", 32'(mem_wr), 32'd0);
        end
        step();
        io_buffer_full = 1'b0;
        @(negedge clk);
        chk("io_release_wr", 32'(mem_wr), 32'd1);
        wait_lsb(t0, 5, "io_st_latency");

        // I/O read ignores the full buffer
        start_lsb(1'b0, 32'h0003_0004, 3'd1, 32'd0, t0);
        io_buffer_full = 1'b1;
        push_rd(32'h0003_0004, 1);
        wait_lsb(t0, 3, "io_ld_latency");
        io_buffer_full = 1'b0;

        // rdy low for 2 cycles after the second address
        start_lsb(1'b0, 32'h1000, 3'd4, 32'd0, t0);
        push_rd(32'h1000, 4);
        repeat (3) step();
        rdy = 1'b0;
        @(negedge clk);
        chk("rdy_low_wr", 32'(mem_wr), 32'd0);
        step();
        step();
        rdy = 1'b1;
        wait_lsb(t0, 8, "rdy_latency");

        // reset in the middle of a store
        start_lsb(1'b1, 32'h0900, 3'd4, 32'h5566_7788, t0);
        push_wr(32'h0900, 3, 32'h5566_7788);
        repeat (3) step();
        rst = 1'b1;
        bus.lsb_en = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_mem_a", mem_a, 32'd0);
        chk("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("mid_rst_lsb_r_data", bus.lsb_r_data, 32'd0);
        chkl("mid_rst_if_data", bus.if_data, '0);
        repeat (10) step();
        @(negedge clk);

        chk("wr_left", 32'(exp_wr.size()), 32'd0);
        chk("lsb_left", 32'(exp_lsb.size()), 32'd0);
        chk("if_left", 32'(exp_if.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
